// File: rtl/regfile_pixio.sv
// regfile_pixio: 2^ADDR_W x DATA_W register file with memory-mapped pixel input slot, output strobe and index.
// Define REGFILE_BYPASS_EN to forward same-cycle core writes to the read ports.
module regfile_pixio #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int PIX_W   = 12,
    parameter int IDX_REG = 11,
    parameter int IMG_REG = 12,
    parameter int WTR_REG = 13,
    parameter int OUT_REG = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              pix_in_valid,
    output logic              pix_in_ready,
    input  logic [PIX_W-1:0]  img_in,
    input  logic [PIX_W-1:0]  wtr_in,
    output logic [PIX_W-1:0]  pix_out,
    output logic              pix_out_valid,
    output logic [PIX_W-1:0]  pix_index
);
    localparam int N = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_A = ADDR_W'(IDX_REG);
    localparam logic [ADDR_W-1:0] IMG_A = ADDR_W'(IMG_REG);
    localparam logic [ADDR_W-1:0] WTR_A = ADDR_W'(WTR_REG);
    localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_REG);

    logic [DATA_W-1:0] regs_q [N];
    logic [DATA_W-1:0] regs_d [N];
    logic              pending_q, pending_d;
    logic              pix_out_valid_q, pix_out_valid_d;
    logic [PIX_W-1:0]  pix_out_q, pix_out_d;
    logic              commit, capture;

    assign commit  = we && waddr == OUT_A;
    assign capture = pix_in_valid && !pending_q;

    // Capture is applied last so it overrides a same-edge core write to IMG/WTR.
    always_comb begin
        regs_d          = regs_q;
        pending_d       = pending_q;
        pix_out_d       = pix_out_q;
        pix_out_valid_d = 1'b0;
        if (we && waddr != '0)
            regs_d[waddr] = wdata;
        if (commit) begin
            pix_out_d       = wdata[PIX_W-1:0];
            pix_out_valid_d = 1'b1;
            regs_d[IDX_A]   = regs_q[IDX_A] + DATA_W'(1);
            pending_d       = 1'b0;
        end
        if (capture) begin
            regs_d[IMG_A] = DATA_W'(img_in);
            regs_d[WTR_A] = DATA_W'(wtr_in);
            pending_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q          <= '{default: '0};
            pending_q       <= 1'b0;
            pix_out_q       <= '0;
            pix_out_valid_q <= 1'b0;
        end else begin
            regs_q          <= regs_d;
            pending_q       <= pending_d;
            pix_out_q       <= pix_out_d;
            pix_out_valid_q <= pix_out_valid_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign rdata1 = (we && waddr != '0 && raddr1 == waddr) ? wdata : regs_q[raddr1];
    assign rdata2 = (we && waddr != '0 && raddr2 == waddr) ? wdata : regs_q[raddr2];
`else
    assign rdata1 = regs_q[raddr1];
    assign rdata2 = regs_q[raddr2];
`endif

    assign pix_in_ready  = !pending_q;
    assign pix_out       = pix_out_q;
    assign pix_out_valid = pix_out_valid_q;
    assign pix_index     = regs_q[IDX_A][PIX_W-1:0];
endmodule

// File: tb/tb_regfile_pixio.sv
// tb_regfile_pixio: randomized + directed stimulus against a behavioural model; expected outputs
// are queued per cycle and a separate monitor compares them on the falling edge.
module tb_regfile_pixio;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0, raddr1 = '0, raddr2 = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata1, rdata2;
    logic        pix_in_valid = 1'b0;
    logic        pix_in_ready;
    logic [11:0] img_in = '0, wtr_in = '0;
    logic [11:0] pix_out, pix_index;
    logic        pix_out_valid;

    regfile_pixio dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
        .img_in(img_in), .wtr_in(wtr_in), .pix_out(pix_out),
        .pix_out_valid(pix_out_valid), .pix_index(pix_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd1, rd2;
        logic        rdy;
        logic [11:0] po;
        logic        pv;
        logic [11:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int n_chk = 0, n_fail = 0;

    // Reference model state: architectural registers, slot occupancy, output latch.
    logic [31:0] m_regs [32];
    logic        m_pend, m_pv;
    logic [11:0] m_pout;

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pend = 1'b0;
        m_pv   = 1'b0;
        m_pout = '0;
    endtask

    function automatic logic [31:0] m_read(logic [4:0] ra, logic w, logic [4:0] wa, logic [31:0] wd);
`ifdef REGFILE_BYPASS_EN
        if (w && wa != 0 && ra == wa) return wd;
`endif
        return m_regs[ra];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rdata1", rdata1, e.rd1);
            chk("rdata2", rdata2, e.rd2);
            chk("pix_in_ready", 32'(pix_in_ready), 32'(e.rdy));
            chk("pix_out", 32'(pix_out), 32'(e.po));
            chk("pix_out_valid", 32'(pix_out_valid), 32'(e.pv));
            chk("pix_index", 32'(pix_index), 32'(e.idx));
        end
    end

    // One cycle: drive just after a rising edge, queue what the outputs must show now,
    // then advance the model across the next rising edge.
    task automatic cyc(logic r, logic w, logic [4:0] wa, logic [31:0] wd,
                       logic [4:0] ra1, logic [4:0] ra2, logic v, logic [11:0] im, logic [11:0] wt);
        exp_t e;
        logic cap, com;
        @(posedge clk);
        #1;
        rst = r; we = w; waddr = wa; wdata = wd; raddr1 = ra1; raddr2 = ra2;
        pix_in_valid = v; img_in = im; wtr_in = wt;
        if (r) m_reset();
        e.rd1 = m_read(ra1, w, wa, wd);
        e.rd2 = m_read(ra2, w, wa, wd);
        e.rdy = !m_pend;
        e.po  = m_pout;
        e.pv  = m_pv;
        e.idx = m_regs[11][11:0];
        exp_q.push_back(e);
        if (!r) begin
            cap  = v && !m_pend;
            com  = w && wa == 5'd14;
            m_pv = 1'b0;
            if (w && wa != 0) m_regs[wa] = wd;
            if (com) begin
                m_pout = wd[11:0];
                m_pv   = 1'b1;
                m_regs[11] = m_regs[11] + 32'd1;
                m_pend = 1'b0;
            end
            if (cap) begin
                m_regs[12] = {20'd0, im};
                m_regs[13] = {20'd0, wt};
                m_pend = 1'b1;
            end
        end
    endtask

    task automatic rnd_cycles(int n);
        logic [4:0] pick [8];
        pick = '{5'd0, 5'd7, 5'd11, 5'd12, 5'd13, 5'd14, 5'd14, 5'd31};
        for (int i = 0; i < n; i++) begin
            logic [4:0] wa;
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : pick[$urandom_range(0, 7)];
            cyc(1'b0, 1'($urandom), wa, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom,
                ($urandom_range(0, 1) == 0) ? wa : 5'($urandom), pick[$urandom_range(0, 7)],
                1'($urandom), 12'($urandom), 12'($urandom));
        end
    endtask

    initial begin
        m_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 11, 12, 0, 0, 0);
        rnd_cycles(40);
        // Asynchronous reset landing between edges, then sweep every register.
        cyc(1, 1, 14, 32'h0000_0ABC, 11, 12, 1, 12'h111, 12'h222);
        cyc(1, 0, 0, 0, 13, 14, 0, 0, 0);
        for (int i = 0; i < 32; i++) cyc(0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0);
        // r0 is hardwired; r7 write latency / forwarding.
        cyc(0, 1, 0, 32'hDEAD_BEEF, 0, 7, 0, 0, 0);
        cyc(0, 1, 7, 32'h1234_5678, 7, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 7, 0, 0, 0, 0);
        // Capture handshake; second pair must be ignored while pending.
        cyc(0, 0, 0, 0, 12, 13, 1, 12'hABC, 12'h123);
        cyc(0, 0, 0, 0, 12, 13, 1, 12'h555, 12'h666);
        cyc(0, 0, 0, 0, 12, 13, 1, 12'h555, 12'h666);
        // Commit with IDX_REG=5.
        cyc(0, 1, 11, 32'd5, 11, 12, 1, 12'h555, 12'h666);
        cyc(0, 1, 14, 32'h0000_0F0F, 14, 11, 1, 12'h555, 12'h666);
        cyc(0, 0, 0, 0, 14, 11, 0, 0, 0);
        cyc(0, 0, 0, 0, 12, 13, 0, 0, 0);
        // Capture beats a same-edge core write to IMG_REG.
        cyc(0, 1, 12, 32'h7, 12, 13, 1, 12'h9AB, 12'h0CD);
        cyc(0, 0, 0, 0, 12, 13, 0, 0, 0);
        // Index wrap, then back-to-back commits.
        cyc(0, 1, 11, 32'hFFFF_FFFF, 11, 0, 0, 0, 0);
        cyc(0, 1, 14, 32'h0000_0123, 11, 14, 0, 0, 0);
        cyc(0, 1, 14, 32'h0000_0456, 11, 14, 1, 12'h777, 12'h888);
        cyc(0, 1, 14, 32'h0000_0789, 11, 14, 0, 0, 0);
        cyc(0, 0, 0, 0, 11, 12, 0, 0, 0);
        cyc(0, 0, 0, 0, 11, 12, 0, 0, 0);
        rnd_cycles(400);
        cyc(0, 0, 0, 0, 11, 14, 0, 0, 0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
